fpu_config_regs: RTL
====================

// Module: fpu_config_regs
// PURPOSE
// - CPU-facing memory-mapped register window that assembles the FPU's 512-bit config line (filter, dims, addresses) and launches a run.
// - Sits directly upstream of the FPU top: drives its start and mapped_data_valid/mapped_data, answers its
//   mapped_data_request/mapped_address fetches and consumes its done.
// - Shadow/active double buffer: CPU programs the next job while the current one runs.
// PARAMETERS
// - START_ADDRESS  32'h1000_0000  byte base of CPU window and the only valid FPU fetch address
// - LINE_WIDTH     512            config line width; 16 x 32-bit words
// - READ_LATENCY   2              cycles from accepted FPU request to fpu_data_valid (>=1)
// PORTS
// - clk            in   1    single clock, all state on rising edge
// - rst            in   1    asynchronous, active-high reset
// - cpu_wr_en      in   1    CPU write strobe, one word per cycle
// - cpu_rd_en      in   1    CPU read strobe (cpu_wr_en wins if both high)
// - cpu_addr       in   32   CPU byte address, word aligned
// - cpu_wr_data    in   32   CPU write data
// - cpu_rd_data    out  32   CPU read data, valid with cpu_rd_valid
// - cpu_rd_valid   out  1    one-cycle pulse, 1 cycle after cpu_rd_en
// - fpu_start      out  1    one-cycle pulse to FPU start
// - fpu_done       in   1    FPU done pulse
// - fpu_data_request in 1    FPU fetch request, held until fpu_data_valid
// - fpu_address    in   32   FPU fetch address
// - fpu_data_valid out  1    one-cycle response pulse
// - fpu_data       out  512  active config line; zero when fpu_data_valid low
// - irq            out  1    level: done_sticky | addr_err
// BEHAVIOUR
// - Reset: all outputs 0; shadow/active lines 0; busy, done_sticky, addr_err 0; FSM IDLE.
// - Map (offset from START_ADDRESS): 0x00-0x3C shadow words 0..15 (word k = line bits [32k+31:32k]), R/W;
//   0x40 CTRL/STATUS: bit0 START (W1, reads 0), bit1 BUSY (RO), bit2 DONE (W1C), bit3 ADDR_ERR (W1C), others 0.
// - Out-of-window CPU write ignored; out-of-window read returns 0 with cpu_rd_valid still pulsed.
// - Read data registered: cpu_rd_data/cpu_rd_valid in cycle after cpu_rd_en; cpu_rd_data 0 otherwise.
// - START written 1 while !busy: active <= shadow (same edge), busy <= 1, fpu_start high the next cycle only.
// - START while busy: ignored, no pulse, no copy. Shadow writes always allowed (never disturb active).
// - fpu_done while busy: busy <= 0, done_sticky <= 1. fpu_done while !busy: ignored.
// - Same-cycle fpu_done and START write: done applied, START ignored (busy was 1); CPU re-issues START.
// - Same-cycle W1C and set of the same bit: set wins.
// - Response FSM (IDLE, WAIT, RESP):
//   IDLE: fpu_data_request=1 -> latch fpu_address, load cnt=READ_LATENCY-1, go WAIT (RESP if latency 1).
//   WAIT: cnt decrements each cycle; at 0 go RESP.
//   RESP: fpu_data_valid=1 one cycle; fpu_data=active line if latched addr==START_ADDRESS,
//         else all-zero and addr_err <= 1; next IDLE.
// - Requester drops fpu_data_request in the cycle after fpu_data_valid; request high in that cycle is
//   a new request. Address/request changes during WAIT are ignored.
// - Active line not updated while busy, so a response in flight always returns the launched config.
// - fpu_data_request with !busy still served (FPU idle prefetch permitted).
// - Reset asserted mid-operation: immediate return to reset values; in-flight response dropped, no valid pulse.
// STRUCTURE
// - Package fpu_cfg_pkg: offsets CFG_WORD0_OFS/CTRL_OFS, CTRL bit indices, NUM_CFG_WORDS=16,
//   typedef enum logic [1:0] {IDLE, WAIT, RESP} fpu_cfg_resp_state_t.
// - One sub-module: fpu_cfg_responder (response FSM + latency counter + address check); register file,
//   CTRL/STATUS and start/done logic stay in the top.
// TESTING
// - Write word0=32'h0102_0304..word15=32'h1F20_2122, read back -> each value, cpu_rd_valid 1 cycle after rd_en.
// - CTRL=1 -> fpu_start one cycle, BUSY=1; request @START_ADDRESS -> fpu_data_valid 2 cycles later, fpu_data==shadow.
// - While busy write word0=32'hDEAD_BEEF, refetch -> fpu_data word0 still 32'h0102_0304; CTRL=1 -> no fpu_start.
// - fpu_done -> BUSY=0, DONE=1, irq=1; write CTRL=4 -> DONE=0, irq=0; then START -> fpu_data word0=32'hDEAD_BEEF.
// - Request @START_ADDRESS+64 -> valid with fpu_data=0, ADDR_ERR=1, irq=1; fpu_done and START same cycle -> no pulse.
// - Assert rst during WAIT -> no fpu_data_valid, all status 0; post-reset read of word3 -> 0.

Source files
------------

// File: rtl/fpu_cfg_pkg.sv
// Shared constants and types for the FPU configuration register window.
package fpu_cfg_pkg;

    localparam int NUM_CFG_WORDS = 16;
    localparam int CFG_IDX_W     = $clog2(NUM_CFG_WORDS);

    localparam logic [31:0] CFG_WORD0_OFS = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFS      = 32'h0000_0040;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_BUSY_BIT     = 1;
    localparam int CTRL_DONE_BIT     = 2;
    localparam int CTRL_ADDR_ERR_BIT = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } fpu_cfg_resp_state_t;

endpackage

// File: rtl/fpu_cfg_responder.sv
// Answers FPU config-line fetches after a fixed latency; only START_ADDRESS returns
// the active line, any other address returns zero and flags an address error.
module fpu_cfg_responder
    import fpu_cfg_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = 32'h1000_0000,
    parameter int          LINE_WIDTH    = 512,
    parameter int          READ_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    input  logic [LINE_WIDTH-1:0] i_line,
    output logic                  o_valid,
    output logic [LINE_WIDTH-1:0] o_data,
    output logic                  o_addr_err
);

    localparam int              CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fpu_cfg_resp_state_t   r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_addr;
    logic                  r_valid;
    logic [LINE_WIDTH-1:0] r_data;
    logic                  r_addr_err;

    logic [31:0] w_rsp_addr;
    logic        w_hit;

    // A latency-1 response is issued straight from IDLE, so the live address is checked there.
    assign w_rsp_addr = (r_state == IDLE) ? i_addr : r_addr;
    assign w_hit      = (w_rsp_addr == START_ADDRESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_addr_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_addr <= i_addr;
                        if (READ_LATENCY == 1) begin
                            r_state <= RESP;
                            r_valid <= 1'b1;
                            if (w_hit) r_data <= i_line;
                            else       r_addr_err <= 1'b1;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == CNT_ONE) begin
                        r_cnt   <= '0;
                        r_state <= RESP;
                        r_valid <= 1'b1;
                        if (w_hit) r_data <= i_line;
                        else       r_addr_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_addr_err = r_addr_err;

endmodule

// File: rtl/fpu_config_regs.sv
// CPU register window holding a shadow/active pair of FPU config lines, with
// START/BUSY/DONE/ADDR_ERR control and a latency-matched fetch responder.
module fpu_config_regs
    import fpu_cfg_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = 32'h1000_0000,
    parameter int          LINE_WIDTH    = 512,
    parameter int          READ_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_wr_en,
    input  logic                  cpu_rd_en,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wr_data,
    output logic [31:0]           cpu_rd_data,
    output logic                  cpu_rd_valid,
    output logic                  fpu_start,
    input  logic                  fpu_done,
    input  logic                  fpu_data_request,
    input  logic [31:0]           fpu_address,
    output logic                  fpu_data_valid,
    output logic [LINE_WIDTH-1:0] fpu_data,
    output logic                  irq
);

    logic [LINE_WIDTH-1:0] r_shadow;
    logic [LINE_WIDTH-1:0] r_active;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_addr_err;
    logic                  r_start;
    logic [31:0]           r_rd_data;
    logic                  r_rd_valid;

    logic [31:0]          w_offset;
    logic                 w_is_cfg;
    logic                 w_is_ctrl;
    logic [CFG_IDX_W-1:0] w_word_idx;
    logic                 w_cfg_wr;
    logic                 w_ctrl_wr;
    logic                 w_start;
    logic                 w_done_set;
    logic                 w_err_set;
    logic                 w_rd_req;
    logic [31:0]          w_rd_word;

    // Addresses below the base wrap to huge offsets, so one compare bounds the window.
    assign w_offset   = cpu_addr - START_ADDRESS;
    assign w_is_cfg   = (w_offset < CTRL_OFS);
    assign w_is_ctrl  = (w_offset == CTRL_OFS);
    assign w_word_idx = w_offset[CFG_IDX_W+1:2];

    assign w_cfg_wr   = cpu_wr_en && w_is_cfg;
    assign w_ctrl_wr  = cpu_wr_en && w_is_ctrl;
    assign w_start    = w_ctrl_wr && cpu_wr_data[CTRL_START_BIT] && !r_busy;
    assign w_done_set = fpu_done && r_busy;
    assign w_rd_req   = cpu_rd_en && !cpu_wr_en;

    always_comb begin
        w_rd_word = '0;
        if (w_is_cfg) begin
            w_rd_word = r_shadow[{w_word_idx, 5'b0} +: 32];
        end else if (w_is_ctrl) begin
            w_rd_word[CTRL_BUSY_BIT]     = r_busy;
            w_rd_word[CTRL_DONE_BIT]     = r_done;
            w_rd_word[CTRL_ADDR_ERR_BIT] = r_addr_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_start    <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_cfg_wr) begin
                r_shadow[{w_word_idx, 5'b0} +: 32] <= cpu_wr_data;
            end

            // Launch and completion are mutually exclusive: one needs !busy, the other busy.
            r_start <= w_start;
            if (w_start) begin
                r_active <= r_shadow;
                r_busy   <= 1'b1;
            end else if (w_done_set) begin
                r_busy <= 1'b0;
            end

            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_ctrl_wr && cpu_wr_data[CTRL_DONE_BIT]) begin
                r_done <= 1'b0;
            end

            if (w_err_set) begin
                r_addr_err <= 1'b1;
            end else if (w_ctrl_wr && cpu_wr_data[CTRL_ADDR_ERR_BIT]) begin
                r_addr_err <= 1'b0;
            end

            r_rd_valid <= w_rd_req;
            r_rd_data  <= w_rd_req ? w_rd_word : 32'h0;
        end
    end

    fpu_cfg_responder #(
        .START_ADDRESS (START_ADDRESS),
        .LINE_WIDTH    (LINE_WIDTH),
        .READ_LATENCY  (READ_LATENCY)
    ) u_responder (
        .clk        (clk),
        .rst        (rst),
        .i_req      (fpu_data_request),
        .i_addr     (fpu_address),
        .i_line     (r_active),
        .o_valid    (fpu_data_valid),
        .o_data     (fpu_data),
        .o_addr_err (w_err_set)
    );

    assign cpu_rd_data  = r_rd_data;
    assign cpu_rd_valid = r_rd_valid;
    assign fpu_start    = r_start;
    assign irq          = r_done | r_addr_err;

endmodule
